// File: rtl/key_event_gen.sv
// Key front end: two-flop sync, per-lane debounce, press-edge capture and
// frame-aligned press events. Define AUTOREPEAT_EN to add held-key auto-repeat.
module key_event_gen #(
    parameter int unsigned      NKEYS        = 8,
    parameter int unsigned      DEBOUNCE_CYC = 16,
    parameter int unsigned      REPEAT_DELAY = 20,
    parameter int unsigned      REPEAT_RATE  = 4,
    parameter logic [NKEYS-1:0] REPEAT_MASK  = NKEYS'(8'h0C)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [NKEYS-1:0] keys_in,
    input  logic             frame_tick,
    output logic [NKEYS-1:0] key_held,
    output logic [NKEYS-1:0] press_evt,
    output logic             missed_evt
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [NKEYS-1:0]         sync1_q, sync2_q;
    logic [NKEYS-1:0]         held_q, held_d;
    logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NKEYS-1:0]         pending_q, pending_d;
    logic [NKEYS-1:0]         evt_q, evt_d;
    logic                     missed_q, missed_d;
    logic [NKEYS-1:0]         rise;
    logic [NKEYS-1:0]         rep;

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        held_d = held_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NKEYS; i++) begin
            if (sync2_q[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                held_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise = held_d & ~held_q;
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned   RW        = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RC_TOP    = RW'(REPEAT_DELAY);
    // Reload one above DELAY-RATE so later repeats land exactly REPEAT_RATE frames apart.
    localparam logic [RW-1:0] RC_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [NKEYS-1:0][RW-1:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        rep  = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (!REPEAT_MASK[i] || !held_q[i]) begin
                rc_d[i] = '0;
            end else if (frame_tick) begin
                if (rc_q[i] == RC_TOP) begin
                    rep[i]  = 1'b1;
                    rc_d[i] = RC_RELOAD;
                end else begin
                    rc_d[i] = rc_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rc_q <= '0;
        else          rc_q <= rc_d;
    end
`else
    assign rep = '0;
`endif

    // A press or repeat in the tick cycle is set after the clear, so it shows next frame.
    always_comb begin
        pending_d = (frame_tick ? '0 : pending_q) | rise | rep;
        evt_d     = frame_tick ? pending_q : evt_q;
        missed_d  = frame_tick ? 1'b0 : (missed_q | (|(rise & pending_q)));
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            held_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            evt_q     <= '0;
            missed_q  <= 1'b0;
        end else begin
            sync1_q   <= keys_in;
            sync2_q   <= sync1_q;
            held_q    <= held_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            evt_q     <= evt_d;
            missed_q  <= missed_d;
        end
    end

    assign key_held   = held_q;
    assign press_evt  = evt_q;
    assign missed_evt = missed_q;

endmodule
